// File: rtl/multi_ch_pio_in.sv
// multi_ch_pio_in: multi-channel Avalon-MM input port with synchronisers, sticky W1C edge capture and maskable irq
module multi_ch_pio_in #(
    parameter int NUM_CH = 4,
    parameter int WIDTH = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE = 0,
    localparam int ADDR_W = $clog2(NUM_CH) + 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    write,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    input  logic [NUM_CH*WIDTH-1:0] in_port,
    output logic                    irq
);
    localparam int N = NUM_CH * WIDTH;
    localparam int AW = $clog2(SYNC_STAGES + 2);
    localparam logic [AW-1:0] ARM_MAX = AW'(SYNC_STAGES + 1);

    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] sync_d [SYNC_STAGES];
    logic [N-1:0] prev_q, prev_d, det, sync;
    logic [WIDTH-1:0] mask_q [NUM_CH];
    logic [WIDTH-1:0] mask_d [NUM_CH];
    logic [WIDTH-1:0] cap_q [NUM_CH];
    logic [WIDTH-1:0] cap_d [NUM_CH];
    logic [WIDTH-1:0] clr;
    logic [AW-1:0] arm_q, arm_d;
    logic [31:0] readdata_q, readdata_d, ch;
    logic [1:0] rsel;
    logic irq_q, irq_d, armed, sel;
    logic unused_wd;

    assign sync = sync_q[SYNC_STAGES-1];
    assign armed = arm_q == ARM_MAX;
    assign ch = 32'(address >> 2);
    assign rsel = address[1:0];
    assign readdata = readdata_q;
    assign irq = irq_q;
    assign unused_wd = ^writedata;

    always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        prev_d = sync;
        arm_d = armed ? arm_q : arm_q + 1'b1;
        det = !armed ? '0 : EDGE_MODE == 0 ? sync & ~prev_q : EDGE_MODE == 1 ? ~sync & prev_q : sync ^ prev_q;
        irq_d = 1'b0;
        readdata_d = '0;
        sel = 1'b0;
        clr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sel = write && ch == 32'(c);
            clr = sel && rsel == 2'd3 ? writedata[WIDTH-1:0] : '0;
            cap_d[c] = (cap_q[c] & ~clr) | det[c*WIDTH +: WIDTH];
            mask_d[c] = sel && rsel == 2'd2 ? writedata[WIDTH-1:0] : mask_q[c];
            irq_d = irq_d | (|(cap_q[c] & mask_q[c]));
            if (ch == 32'(c))
                readdata_d = rsel == 2'd0 ? 32'(sync[c*WIDTH +: WIDTH]) :
                             rsel == 2'd2 ? 32'(mask_q[c]) :
                             rsel == 2'd3 ? 32'(cap_q[c]) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '{default: '0};
            mask_q <= '{default: '0};
            cap_q <= '{default: '0};
            prev_q <= '0;
            arm_q <= '0;
            readdata_q <= '0;
            irq_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            mask_q <= mask_d;
            cap_q <= cap_d;
            prev_q <= prev_d;
            arm_q <= arm_d;
            readdata_q <= readdata_d;
            irq_q <= irq_d;
        end
    end
endmodule
